pifo_calendar_sorted: RTL and testbench
=======================================

Name: pifo_calendar_sorted

Overview:
Parametrised push-in-first-out calendar: a register-array PIFO that holds (rank, buffer address) pairs sorted by ascending rank.
- Supports insert and pop in the same cycle, with configurable depth, rank width and address width.
- Selectable full-queue policy: reject the new entry, or evict the tail (lowest priority).
- Sits between the enqueue agent and the egress scheduler; it is the next-generation root calendar of the PIFO scheduler.

Parameters:
PIFO_CALENDAR_SIZE, 16, number of entries (2..64)
RANK_WIDTH, 16, rank width; a lower rank pops first
BUFFER_ADDR_WIDTH, 12, packet buffer address width
PIFO_CALENDAR_INDEX_WIDTH, 5, count width; must be >= clog2(PIFO_CALENDAR_SIZE+1)
DROP_MODE, 0, 0 = reject the insert when full; 1 = evict the tail when the new rank is strictly lower than the tail rank

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
s_axis_insert_en  in  1  insert request, single-cycle pulse
s_axis_rank  in  RANK_WIDTH  rank of the inserted entry
s_axis_buffer_addr  in  BUFFER_ADDR_WIDTH  address of the inserted entry
s_axis_pop_en  in  1  pop request
m_axis_pifo_calendar_top  out  RANK_WIDTH  rank in slot 0
m_axis_top_valid  out  1  slot 0 is occupied
m_axis_buffer_addr  out  BUFFER_ADDR_WIDTH  address of the popped entry
m_axis_pop_valid  out  1  m_axis_buffer_addr is valid (one-cycle pulse)
m_axis_drop_valid  out  1  an entry was dropped or evicted (pulse)
m_axis_drop_addr  out  BUFFER_ADDR_WIDTH  address of the dropped or evicted entry
m_axis_calendar_full  out  1  count == PIFO_CALENDAR_SIZE
m_axis_calendar_empty  out  1  count == 0
m_axis_calendar_count  out  PIFO_CALENDAR_INDEX_WIDTH  number of occupied slots

Behaviour:
- State
  - Slots 0..SIZE-1, each holding valid, rank and addr.
  - Valid slots are contiguous from slot 0 and sorted non-decreasing by rank.
  - All outputs are registered.
- Reset
  - All slot valids = 0; count = 0; empty = 1; full = 0.
  - All pulse outputs, top rank and all addresses = 0.
  - Reset asserted mid-operation discards all contents immediately; there is no flush sequence.
- Pop (pop_en=1, count>0)
  - Slot 0 is removed at the clock edge.
  - m_axis_buffer_addr = old slot0.addr and m_axis_pop_valid = 1 in the cycle after the request (latency 1).
  - Remaining slots shift down by one.
- Pop on empty: ignored; pop_valid stays 0; state is unchanged, apart from any concurrent insert.
- Insert position
  - Computed on the post-pop view of the array.
  - pos = number of valid post-pop slots with rank <= s_axis_rank, so equal ranks are FIFO-ordered.
  - Slots at index >= pos shift up by one; the new entry is written at pos.
- Simultaneous pop and insert
  - Pop and insert both occur; count is unchanged.
  - Allowed when full: no drop occurs.
  - If a new rank is lower than the old head, the new entry becomes the top in the next cycle; the popped entry is still the old head.
- Full, insert without pop, DROP_MODE=0
  - Insert is rejected and the state is unchanged.
  - drop_valid=1 with drop_addr = s_axis_buffer_addr.
- Full, insert without pop, DROP_MODE=1
  - If s_axis_rank < tail rank: the tail is evicted, the new entry is inserted at pos, and drop_addr = old tail addr.
  - Otherwise the new entry is dropped, exactly as in mode 0.
  - Count stays at SIZE in both cases.
- Outputs
  - count updates in the cycle after the request: +1 on insert only, -1 on pop only.
  - full and empty are derived from the next count and are registered with it.
  - top rank and top_valid reflect the registered slot 0.
  - pop_valid and drop_valid are each high for exactly one cycle per event; both may be high in the same cycle.
- Arithmetic
  - Rank comparison is unsigned with no wrap-around handling; the rank source must stay within range.
  - count never exceeds SIZE.

Decomposition:
- Package pifo_calendar_pkg holds:
  - slot typedef {valid, rank, addr};
  - DROP_MODE encodings;
  - clog2 function.
- One natural sub-module, pifo_slot_cell. It holds one slot and selects its next value from its current value, its lower neighbour, its upper neighbour or the new entry. The selection is driven by shift and insert-position strobes from the top level.
- The top level contains the comparator vector, the pos one-hot encoder, count and the output registers.

Test Plan:
- Ranks 30, 10, 20 inserted with addrs 0x003, 0x001, 0x002, one per cycle, then 3 pops → pop addrs 0x001, 0x002, 0x003 on consecutive cycles; count goes 3, 2, 1, 0; empty=1 after the last pop.
- Ranks 5, 5, 5 inserted with addrs 0xA, 0xB, 0xC, then drained → addrs 0xA, 0xB, 0xC (FIFO tie-break).
- With SIZE=4 holding ranks 1..4, pop and insert rank 0 / addr 0x0FF in the same cycle → pop addr is the rank-1 entry; top=0; count=4; full=1; drop_valid=0.
- With SIZE=4 full, DROP_MODE=0, insert rank 0 / addr 0x055 → drop_valid=1, drop_addr=0x055; contents unchanged.
- With SIZE=4 full with ranks 1..4, DROP_MODE=1: insert rank 2 → rank-4 tail evicted and its addr reported; order 1, 2, 2, 3. Then insert rank 9 → the new entry is dropped.
- Pop on empty together with insert rank 7, then rst asserted mid-stream after 3 inserts → first: pop_valid=0, count=1, top=7; after reset: count=0, empty=1, all pulses 0 asynchronously.

Source files
------------

// File: rtl/pifo_calendar_sorted_pkg.sv
// pifo_calendar_pkg: slot layout, drop-mode encodings and sizing helper shared by the sorted PIFO calendar
package pifo_calendar_pkg;
    localparam int DEF_RANK_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 12;
    typedef enum logic {
        DROP_REJECT = 1'b0,
        DROP_EVICT_TAIL = 1'b1
    } drop_mode_e;
    typedef struct packed {
        logic valid;
        logic [DEF_RANK_WIDTH-1:0] rank;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } slot_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/pifo_calendar_sorted_if.sv
// pifo_calendar_sorted_if: insert/pop request bus and registered status outputs of the PIFO calendar
interface pifo_calendar_sorted_if
    import pifo_calendar_pkg::*;
#(
    parameter int PIFO_CALENDAR_SIZE = 16,
    parameter int RANK_WIDTH = DEF_RANK_WIDTH,
    parameter int BUFFER_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PIFO_CALENDAR_INDEX_WIDTH = clog2(PIFO_CALENDAR_SIZE + 1)
);
    logic s_axis_insert_en;
    logic [RANK_WIDTH-1:0] s_axis_rank;
    logic [BUFFER_ADDR_WIDTH-1:0] s_axis_buffer_addr;
    logic s_axis_pop_en;
    logic [RANK_WIDTH-1:0] m_axis_pifo_calendar_top;
    logic m_axis_top_valid;
    logic [BUFFER_ADDR_WIDTH-1:0] m_axis_buffer_addr;
    logic m_axis_pop_valid;
    logic m_axis_drop_valid;
    logic [BUFFER_ADDR_WIDTH-1:0] m_axis_drop_addr;
    logic m_axis_calendar_full;
    logic m_axis_calendar_empty;
    logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] m_axis_calendar_count;
    modport slave (
        input s_axis_insert_en, s_axis_rank, s_axis_buffer_addr, s_axis_pop_en,
        output m_axis_pifo_calendar_top, m_axis_top_valid, m_axis_buffer_addr, m_axis_pop_valid,
        output m_axis_drop_valid, m_axis_drop_addr, m_axis_calendar_full, m_axis_calendar_empty,
        output m_axis_calendar_count
    );
    modport master (
        output s_axis_insert_en, s_axis_rank, s_axis_buffer_addr, s_axis_pop_en,
        input m_axis_pifo_calendar_top, m_axis_top_valid, m_axis_buffer_addr, m_axis_pop_valid,
        input m_axis_drop_valid, m_axis_drop_addr, m_axis_calendar_full, m_axis_calendar_empty,
        input m_axis_calendar_count
    );
endinterface

// File: rtl/pifo_calendar_sorted_slot_cell.sv
// pifo_slot_cell: one calendar slot {valid, rank, addr}; loads new entry, a neighbour, or holds
module pifo_slot_cell
    import pifo_calendar_pkg::*;
#(
    parameter int W = $bits(slot_t)
) (
    input logic clk,
    input logic rst,
    input logic ins_i,
    input logic up_i,
    input logic down_i,
    input logic [W-1:0] new_i,
    input logic [W-1:0] lower_i,
    input logic [W-1:0] upper_i,
    output logic [W-1:0] slot_o
);
    logic [W-1:0] slot_d, slot_q;
    // shifting up while the head pops cancels out, so the slot keeps its own value
    always_comb slot_d = ins_i ? new_i : up_i ? (down_i ? slot_q : lower_i) : down_i ? upper_i : slot_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_q <= '0;
        else slot_q <= slot_d;
    end
    assign slot_o = slot_q;
endmodule

// File: rtl/pifo_calendar_sorted.sv
// pifo_calendar_sorted: register-array PIFO keeping (rank, addr) pairs sorted by ascending rank
module pifo_calendar_sorted
    import pifo_calendar_pkg::*;
#(
    parameter int PIFO_CALENDAR_SIZE = 16,
    parameter int RANK_WIDTH = DEF_RANK_WIDTH,
    parameter int BUFFER_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int PIFO_CALENDAR_INDEX_WIDTH = 5,
    parameter int DROP_MODE = 0
) (
    input logic clk,
    input logic rst,
    pifo_calendar_sorted_if.slave bus
);
    localparam int N = PIFO_CALENDAR_SIZE;
    localparam int RW = RANK_WIDTH;
    localparam int AW = BUFFER_ADDR_WIDTH;
    localparam int IW = PIFO_CALENDAR_INDEX_WIDTH;
    localparam int W = 1 + RW + AW;
    localparam bit EVICT = DROP_MODE == int'(DROP_EVICT_TAIL);
    logic [W-1:0] slot_q [N];
    logic [W-1:0] lower [N];
    logic [W-1:0] upper [N];
    logic [W-1:0] pp [N];
    logic [W-1:0] new_slot;
    logic [N-1:0] le, le_prev, ins, up;
    logic do_pop, insert_ok, drop, grow, shrink;
    logic [IW-1:0] count_d, count_q;
    logic full_d, full_q, empty_d, empty_q;
    logic pop_valid_d, pop_valid_q, drop_valid_d, drop_valid_q;
    logic [AW-1:0] buffer_addr_d, buffer_addr_q, drop_addr_d, drop_addr_q;
    assign do_pop = bus.s_axis_pop_en && !empty_q;
    assign new_slot = {1'b1, bus.s_axis_rank, bus.s_axis_buffer_addr};
    for (genvar i = 0; i < N; i++) begin : g_slot
        if (i == 0) begin : g_bot
            assign lower[i] = '0;
        end else begin : g_low
            assign lower[i] = slot_q[i-1];
        end
        if (i == N - 1) begin : g_top
            assign upper[i] = '0;
        end else begin : g_up
            assign upper[i] = slot_q[i+1];
        end
        // le is a prefix of ones over the post-pop view; equal ranks stay ahead of the newcomer
        assign pp[i] = do_pop ? upper[i] : slot_q[i];
        assign le[i] = pp[i][W-1] && pp[i][W-2 -: RW] <= bus.s_axis_rank;
        pifo_slot_cell #(.W(W)) u_cell (
            .clk(clk),
            .rst(rst),
            .ins_i(ins[i]),
            .up_i(up[i]),
            .down_i(do_pop),
            .new_i(new_slot),
            .lower_i(lower[i]),
            .upper_i(upper[i]),
            .slot_o(slot_q[i])
        );
    end
    always_comb begin
        insert_ok = bus.s_axis_insert_en
                    && (!full_q || do_pop || (EVICT && bus.s_axis_rank < slot_q[N-1][W-2 -: RW]));
        le_prev = {le[N-2:0], 1'b1};
        ins = insert_ok ? le_prev & ~le : '0;
        up = insert_ok ? ~le_prev : '0;
        drop = bus.s_axis_insert_en && full_q && !do_pop;
        grow = insert_ok && !do_pop && !full_q;
        shrink = do_pop && !insert_ok;
        count_d = count_q + IW'(grow) - IW'(shrink);
        full_d = count_d == IW'(N);
        empty_d = count_d == '0;
        pop_valid_d = do_pop;
        buffer_addr_d = do_pop ? slot_q[0][AW-1:0] : buffer_addr_q;
        drop_valid_d = drop;
        drop_addr_d = drop ? (insert_ok ? slot_q[N-1][AW-1:0] : bus.s_axis_buffer_addr) : drop_addr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
            pop_valid_q <= 1'b0;
            buffer_addr_q <= '0;
            drop_valid_q <= 1'b0;
            drop_addr_q <= '0;
        end else begin
            count_q <= count_d;
            full_q <= full_d;
            empty_q <= empty_d;
            pop_valid_q <= pop_valid_d;
            buffer_addr_q <= buffer_addr_d;
            drop_valid_q <= drop_valid_d;
            drop_addr_q <= drop_addr_d;
        end
    end
    assign bus.m_axis_pifo_calendar_top = slot_q[0][W-2 -: RW];
    assign bus.m_axis_top_valid = slot_q[0][W-1];
    assign bus.m_axis_buffer_addr = buffer_addr_q;
    assign bus.m_axis_pop_valid = pop_valid_q;
    assign bus.m_axis_drop_valid = drop_valid_q;
    assign bus.m_axis_drop_addr = drop_addr_q;
    assign bus.m_axis_calendar_full = full_q;
    assign bus.m_axis_calendar_empty = empty_q;
    assign bus.m_axis_calendar_count = count_q;
endmodule

// File: tb/tb_pifo_calendar_sorted.sv
// tb_pifo_calendar_sorted: drives reject-mode and evict-mode calendars with one stimulus, checks against queue models
module tb_pifo_calendar_sorted;
    localparam int SIZE = 4;
    typedef struct {
        logic [15:0] rank;
        logic [11:0] addr;
    } ent_t;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    pifo_calendar_sorted_if #(.PIFO_CALENDAR_SIZE(SIZE)) bus0 ();
    pifo_calendar_sorted_if #(.PIFO_CALENDAR_SIZE(SIZE)) bus1 ();
    pifo_calendar_sorted #(.PIFO_CALENDAR_SIZE(SIZE), .PIFO_CALENDAR_INDEX_WIDTH(3), .DROP_MODE(0)) u_rej (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    pifo_calendar_sorted #(.PIFO_CALENDAR_SIZE(SIZE), .PIFO_CALENDAR_INDEX_WIDTH(3), .DROP_MODE(1)) u_evt (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    int n_vec = 0;
    int n_bad = 0;
    bit armed = 0;
    ent_t mq0[$];
    ent_t mq1[$];
    ent_t w[$];
    bit e_pv[2];
    bit e_dv[2];
    logic [11:0] e_pa[2];
    logic [11:0] e_da[2];
    int e_cnt[2];
    logic [15:0] e_top[2];
    logic [15:0] d_top[2];
    logic d_tv[2], d_pv[2], d_dv[2], d_full[2], d_empty[2];
    logic [11:0] d_pa[2], d_da[2];
    logic [2:0] d_cnt[2];
    assign d_top = '{bus0.m_axis_pifo_calendar_top, bus1.m_axis_pifo_calendar_top};
    assign d_tv = '{bus0.m_axis_top_valid, bus1.m_axis_top_valid};
    assign d_pv = '{bus0.m_axis_pop_valid, bus1.m_axis_pop_valid};
    assign d_dv = '{bus0.m_axis_drop_valid, bus1.m_axis_drop_valid};
    assign d_full = '{bus0.m_axis_calendar_full, bus1.m_axis_calendar_full};
    assign d_empty = '{bus0.m_axis_calendar_empty, bus1.m_axis_calendar_empty};
    assign d_pa = '{bus0.m_axis_buffer_addr, bus1.m_axis_buffer_addr};
    assign d_da = '{bus0.m_axis_drop_addr, bus1.m_axis_drop_addr};
    assign d_cnt = '{bus0.m_axis_calendar_count, bus1.m_axis_calendar_count};

    function automatic void chk(input string n, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endfunction

    // Sorted-queue model: pop the head, then insert behind every entry of equal or lower rank
    function automatic void model_step(input int m, input bit ins, input int r, input int a, input bit pop);
        ent_t t;
        int k;
        bit take;
        if (m == 0) w = mq0; else w = mq1;
        e_pv[m] = pop && w.size() > 0;
        e_dv[m] = 0;
        if (e_pv[m]) begin
            t = w.pop_front();
            e_pa[m] = t.addr;
        end
        take = ins && w.size() < SIZE;
        if (ins && !take) begin
            e_dv[m] = 1;
            if (m == 1 && 16'(r) < w[w.size()-1].rank) begin
                e_da[m] = w[w.size()-1].addr;
                void'(w.pop_back());
                take = 1;
            end else e_da[m] = 12'(a);
        end
        if (take) begin
            k = 0;
            while (k < w.size() && w[k].rank <= 16'(r)) k++;
            t.rank = 16'(r);
            t.addr = 12'(a);
            w.insert(k, t);
        end
        e_cnt[m] = w.size();
        e_top[m] = w.size() > 0 ? w[0].rank : 16'h0;
        if (m == 0) mq0 = w; else mq1 = w;
    endfunction

    function automatic void model_reset();
        mq0.delete();
        mq1.delete();
        for (int m = 0; m < 2; m++) begin
            e_pv[m] = 0;
            e_dv[m] = 0;
            e_cnt[m] = 0;
            e_top[m] = '0;
        end
    endfunction

    task automatic drive(input bit ins, input int r, input int a, input bit pop);
        bus0.s_axis_insert_en = ins;
        bus0.s_axis_rank = 16'(r);
        bus0.s_axis_buffer_addr = 12'(a);
        bus0.s_axis_pop_en = pop;
        bus1.s_axis_insert_en = ins;
        bus1.s_axis_rank = 16'(r);
        bus1.s_axis_buffer_addr = 12'(a);
        bus1.s_axis_pop_en = pop;
    endtask

    task automatic step(input bit ins, input int r, input int a, input bit pop);
        @(negedge clk);
        drive(ins, r, a, pop);
        @(posedge clk);
        model_step(0, ins, r, a, pop);
        model_step(1, ins, r, a, pop);
        #1;
        drive(0, 0, 0, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " m0 count"}, int'(bus0.m_axis_calendar_count), 0);
        chk({tag, " m0 empty"}, int'(bus0.m_axis_calendar_empty), 1);
        chk({tag, " m0 full"}, int'(bus0.m_axis_calendar_full), 0);
        chk({tag, " m0 pop_valid"}, int'(bus0.m_axis_pop_valid), 0);
        chk({tag, " m0 drop_valid"}, int'(bus0.m_axis_drop_valid), 0);
        chk({tag, " m0 top_valid"}, int'(bus0.m_axis_top_valid), 0);
        chk({tag, " m0 top"}, int'(bus0.m_axis_pifo_calendar_top), 0);
        chk({tag, " m0 pop_addr"}, int'(bus0.m_axis_buffer_addr), 0);
        chk({tag, " m1 count"}, int'(bus1.m_axis_calendar_count), 0);
        chk({tag, " m1 empty"}, int'(bus1.m_axis_calendar_empty), 1);
        chk({tag, " m1 pop_valid"}, int'(bus1.m_axis_pop_valid), 0);
        chk({tag, " m1 drop_addr"}, int'(bus1.m_axis_drop_addr), 0);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("m%0d count", m), int'(d_cnt[m]), e_cnt[m]);
                chk($sformatf("m%0d full", m), int'(d_full[m]), int'(e_cnt[m] == SIZE));
                chk($sformatf("m%0d empty", m), int'(d_empty[m]), int'(e_cnt[m] == 0));
                chk($sformatf("m%0d top_valid", m), int'(d_tv[m]), int'(e_cnt[m] != 0));
                if (e_cnt[m] != 0) chk($sformatf("m%0d top", m), int'(d_top[m]), int'(e_top[m]));
                chk($sformatf("m%0d pop_valid", m), int'(d_pv[m]), int'(e_pv[m]));
                if (e_pv[m]) chk($sformatf("m%0d pop_addr", m), int'(d_pa[m]), int'(e_pa[m]));
                chk($sformatf("m%0d drop_valid", m), int'(d_dv[m]), int'(e_dv[m]));
                if (e_dv[m]) chk($sformatf("m%0d drop_addr", m), int'(d_da[m]), int'(e_da[m]));
            end
        end
    end

    initial begin
        int x0[4];
        int x1[4];
        rst = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        armed = 1;
        // ascending-rank ordering
        step(1, 30, 'h003, 0);
        step(1, 10, 'h001, 0);
        step(1, 20, 'h002, 0);
        chk("t1 count3", int'(bus0.m_axis_calendar_count), 3);
        chk("t1 top10", int'(bus0.m_axis_pifo_calendar_top), 10);
        x0 = '{'h001, 'h002, 'h003, 0};
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1);
            chk($sformatf("t1 pop%0d valid", k), int'(bus0.m_axis_pop_valid), 1);
            chk($sformatf("t1 pop%0d addr", k), int'(bus0.m_axis_buffer_addr), x0[k]);
            chk($sformatf("t1 pop%0d count", k), int'(bus0.m_axis_calendar_count), 2 - k);
        end
        chk("t1 empty", int'(bus0.m_axis_calendar_empty), 1);
        // equal ranks leave in arrival order
        step(1, 5, 'h00A, 0);
        step(1, 5, 'h00B, 0);
        step(1, 5, 'h00C, 0);
        x0 = '{'h00A, 'h00B, 'h00C, 0};
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1);
            chk($sformatf("t2 pop%0d addr", k), int'(bus0.m_axis_buffer_addr), x0[k]);
        end
        // pop and insert together while full
        for (int k = 1; k <= 4; k++) step(1, k, 'h010 + k, 0);
        chk("t3 full", int'(bus0.m_axis_calendar_full), 1);
        step(1, 0, 'h0FF, 1);
        chk("t3 pop_addr", int'(bus0.m_axis_buffer_addr), 'h011);
        chk("t3 top", int'(bus0.m_axis_pifo_calendar_top), 0);
        chk("t3 count", int'(bus0.m_axis_calendar_count), 4);
        chk("t3 full after", int'(bus0.m_axis_calendar_full), 1);
        chk("t3 m0 drop_valid", int'(bus0.m_axis_drop_valid), 0);
        chk("t3 m1 drop_valid", int'(bus1.m_axis_drop_valid), 0);
        // full insert without pop: mode 0 rejects, mode 1 evicts its rank-4 tail
        step(1, 0, 'h055, 0);
        chk("t4 m0 drop_valid", int'(bus0.m_axis_drop_valid), 1);
        chk("t4 m0 drop_addr", int'(bus0.m_axis_drop_addr), 'h055);
        chk("t4 m1 drop_addr", int'(bus1.m_axis_drop_addr), 'h014);
        chk("t4 m0 count", int'(bus0.m_axis_calendar_count), 4);
        x0 = '{'h0FF, 'h012, 'h013, 'h014};
        x1 = '{'h0FF, 'h055, 'h012, 'h013};
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1);
            chk($sformatf("t4 m0 drain%0d", k), int'(bus0.m_axis_buffer_addr), x0[k]);
            chk($sformatf("t4 m1 drain%0d", k), int'(bus1.m_axis_buffer_addr), x1[k]);
        end
        // evict-mode: lower rank evicts the tail, higher rank is dropped
        for (int k = 1; k <= 4; k++) step(1, k, 'h020 + k, 0);
        step(1, 2, 'h0AA, 0);
        chk("t5 m1 drop_valid", int'(bus1.m_axis_drop_valid), 1);
        chk("t5 m1 drop_addr", int'(bus1.m_axis_drop_addr), 'h024);
        chk("t5 m0 drop_addr", int'(bus0.m_axis_drop_addr), 'h0AA);
        chk("t5 m1 count", int'(bus1.m_axis_calendar_count), 4);
        step(1, 9, 'h0BB, 0);
        chk("t5 m1 drop9 valid", int'(bus1.m_axis_drop_valid), 1);
        chk("t5 m1 drop9 addr", int'(bus1.m_axis_drop_addr), 'h0BB);
        x0 = '{'h021, 'h022, 'h023, 'h024};
        x1 = '{'h021, 'h022, 'h0AA, 'h023};
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1);
            chk($sformatf("t5 m0 drain%0d", k), int'(bus0.m_axis_buffer_addr), x0[k]);
            chk($sformatf("t5 m1 drain%0d", k), int'(bus1.m_axis_buffer_addr), x1[k]);
        end
        // pop on empty with concurrent insert, then reset mid-stream
        step(1, 7, 'h077, 1);
        chk("t6 pop_valid", int'(bus0.m_axis_pop_valid), 0);
        chk("t6 count", int'(bus0.m_axis_calendar_count), 1);
        chk("t6 top", int'(bus0.m_axis_pifo_calendar_top), 7);
        step(1, 8, 'h078, 0);
        step(1, 9, 'h079, 0);
        step(1, 3, 'h033, 1);
        chk("t6 pop before rst", int'(bus0.m_axis_pop_valid), 1);
        chk("t6 addr before rst", int'(bus0.m_axis_buffer_addr), 'h077);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        step(1, 4, 'h044, 0);
        chk("post count", int'(bus0.m_axis_calendar_count), 1);
        chk("post top", int'(bus0.m_axis_pifo_calendar_top), 4);
        step(0, 0, 0, 1);
        chk("post pop_addr", int'(bus0.m_axis_buffer_addr), 'h044);
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
